// File: rtl/axi4_lite_pkg.sv
// Shared AXI4-Lite definitions: bus configuration, response codes and the
// joiner state encoding used by the read-side (and future write-side) joiner.
package axi4_lite_pkg;

  typedef struct packed {
    int unsigned addr_w;
    int unsigned data_w;
  } axi4_lite_cfg_t;

  localparam axi4_lite_cfg_t AXI4_LITE_CFG_DEFAULT = '{addr_w: 32'd32, data_w: 32'd32};

  localparam int unsigned PROT_W = 3;
  localparam int unsigned RESP_W = 2;

  localparam logic [RESP_W-1:0] RESP_OKAY   = 2'b00;
  localparam logic [RESP_W-1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    JOIN_IDLE  = 3'd0,
    JOIN_ADDR  = 3'd1,
    JOIN_DATA  = 3'd2,
    JOIN_ERR   = 3'd3,
    JOIN_DRAIN = 3'd4
  } join_state_e;

endpackage

// File: rtl/axi4_lite_if.sv
// AXI4-Lite bundle; master drives requests, slave drives responses.
interface axi4_lite_if #(
  parameter axi4_lite_pkg::axi4_lite_cfg_t C = axi4_lite_pkg::AXI4_LITE_CFG_DEFAULT
);
  import axi4_lite_pkg::*;

  logic                  awvalid;
  logic                  awready;
  logic [C.addr_w-1:0]   awaddr;
  logic [PROT_W-1:0]     awprot;
  logic                  wvalid;
  logic                  wready;
  logic [C.data_w-1:0]   wdata;
  logic [C.data_w/8-1:0] wstrb;
  logic                  bvalid;
  logic                  bready;
  logic [RESP_W-1:0]     bresp;
  logic                  arvalid;
  logic                  arready;
  logic [C.addr_w-1:0]   araddr;
  logic [PROT_W-1:0]     arprot;
  logic                  rvalid;
  logic                  rready;
  logic [C.data_w-1:0]   rdata;
  logic [RESP_W-1:0]     rresp;

  modport master (
    output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
           arvalid, araddr, arprot, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

  modport slave (
    input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
           arvalid, araddr, arprot, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

endinterface

// File: rtl/axi4_lite_rr_arb_2.sv
// Two-way round-robin pick: a lone requester wins, on contention the port
// that was not served last wins.
module axi4_lite_rr_arb_2 (
  input  logic [1:0] request,
  input  logic       last_g,
  output logic       grant_c
);

  always_comb begin
    grant_c = 1'b0;
    if (request == 2'b11) begin
      grant_c = ~last_g;
    end else begin
      grant_c = request[1];
    end
  end

endmodule

// File: rtl/axi4_lite_bus_join_rd.sv
// Two-requester AXI4-Lite read joiner, one transaction in flight, round-robin.
// Define AXI4_LITE_BUS_JOIN_RD_WATCHDOG_EN to turn hung reads into SLVERR.
module axi4_lite_bus_join_rd
  import axi4_lite_pkg::*;
#(
  parameter axi4_lite_cfg_t C       = AXI4_LITE_CFG_DEFAULT,
  parameter int unsigned    TIMEOUT = 256
) (
  input  logic        aclk,
  input  logic        aresetn,
  axi4_lite_if.slave  axi4_s [2],
  axi4_lite_if.master axi4_m,
  output logic        timeout_o
);

  localparam int unsigned AW = C.addr_w;

  join_state_e       state_q, state_d;
  logic              g_q, g_d;
  logic              last_g_q, last_g_d;
  logic              grant_c;
  logic              r_hs_c;
  logic              in_err_c;
  logic              in_drain_c;
  logic [1:0]        s_arvalid_c;
  logic [1:0]        s_rready_c;
  logic [AW-1:0]     s_araddr_c [2];
  logic [PROT_W-1:0] s_arprot_c [2];
  logic [1:0]        unused_s_c;
  logic              unused_m_c;

  // Per-port fan-in/fan-out; only the granted port ever sees a ready or valid.
  for (genvar i = 0; i < 2; i++) begin : g_port
    logic sel_c;
    assign sel_c          = (g_q == 1'(i));
    assign s_arvalid_c[i] = axi4_s[i].arvalid;
    assign s_rready_c[i]  = axi4_s[i].rready;
    assign s_araddr_c[i]  = axi4_s[i].araddr;
    assign s_arprot_c[i]  = axi4_s[i].arprot;

    assign axi4_s[i].arready = sel_c && (state_q == JOIN_ADDR) && axi4_m.arready;
    assign axi4_s[i].rvalid  = sel_c && (((state_q == JOIN_DATA) && axi4_m.rvalid) || in_err_c);
    assign axi4_s[i].rdata   = (sel_c && (state_q == JOIN_DATA)) ? axi4_m.rdata : '0;
    assign axi4_s[i].rresp   = (sel_c && (state_q == JOIN_DATA)) ? axi4_m.rresp :
                               (sel_c && in_err_c)               ? RESP_SLVERR  : RESP_OKAY;

    assign axi4_s[i].awready = 1'b0;
    assign axi4_s[i].wready  = 1'b0;
    assign axi4_s[i].bvalid  = 1'b0;
    assign axi4_s[i].bresp   = '0;

    assign unused_s_c[i] = ^{axi4_s[i].awvalid, axi4_s[i].awaddr, axi4_s[i].awprot,
                             axi4_s[i].wvalid, axi4_s[i].wdata, axi4_s[i].wstrb,
                             axi4_s[i].bready};
  end

  assign axi4_m.arvalid = (state_q == JOIN_ADDR);
  assign axi4_m.araddr  = (state_q == JOIN_ADDR) ? s_araddr_c[g_q] : '0;
  assign axi4_m.arprot  = (state_q == JOIN_ADDR) ? s_arprot_c[g_q] : '0;
  assign axi4_m.rready  = ((state_q == JOIN_DATA) && s_rready_c[g_q]) || in_drain_c;

  assign axi4_m.awvalid = 1'b0;
  assign axi4_m.awaddr  = '0;
  assign axi4_m.awprot  = '0;
  assign axi4_m.wvalid  = 1'b0;
  assign axi4_m.wdata   = '0;
  assign axi4_m.wstrb   = '0;
  assign axi4_m.bready  = 1'b0;

  assign unused_m_c = ^{axi4_m.awready, axi4_m.wready, axi4_m.bvalid, axi4_m.bresp};

  axi4_lite_rr_arb_2 u_arb (
    .request (s_arvalid_c),
    .last_g  (last_g_q),
    .grant_c (grant_c)
  );

  assign r_hs_c = axi4_m.rvalid && s_rready_c[g_q];

`ifdef AXI4_LITE_BUS_JOIN_RD_WATCHDOG_EN
  localparam int unsigned      CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;

  assign in_err_c   = (state_q == JOIN_ERR);
  assign in_drain_c = (state_q == JOIN_DRAIN);
  assign timeout_o  = timeout_q;

  // Counter restarts on every state change and saturates rather than wrapping.
  always_comb begin
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (((state_q == JOIN_DATA) || (state_q == JOIN_DRAIN)) && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    if ((state_q == JOIN_DATA) && (state_d == JOIN_ERR)) begin
      timeout_d = 1'b1;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end
`else
  localparam int unsigned unused_timeout_p = TIMEOUT;

  assign in_err_c   = 1'b0;
  assign in_drain_c = 1'b0;
  assign timeout_o  = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    g_d      = g_q;
    last_g_d = last_g_q;
    case (state_q)
      JOIN_IDLE: begin
        if (|s_arvalid_c) begin
          g_d     = grant_c;
          state_d = JOIN_ADDR;
        end
      end
      JOIN_ADDR: begin
        if (axi4_m.arready) state_d = JOIN_DATA;
      end
      JOIN_DATA: begin
        // A handshake in the last counted cycle still beats the watchdog.
        if (r_hs_c) begin
          state_d  = JOIN_IDLE;
          last_g_d = g_q;
        end
`ifdef AXI4_LITE_BUS_JOIN_RD_WATCHDOG_EN
        else if (cnt_q == CNT_LAST) begin
          state_d = JOIN_ERR;
        end
`endif
      end
`ifdef AXI4_LITE_BUS_JOIN_RD_WATCHDOG_EN
      JOIN_ERR: begin
        if (s_rready_c[g_q]) begin
          state_d  = JOIN_DRAIN;
          last_g_d = g_q;
        end
      end
      JOIN_DRAIN: begin
        if (axi4_m.rvalid || (cnt_q == CNT_LAST)) state_d = JOIN_IDLE;
      end
`endif
      default: state_d = JOIN_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q  <= JOIN_IDLE;
      g_q      <= 1'b0;
      last_g_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      g_q      <= g_d;
      last_g_q <= last_g_d;
    end
  end

endmodule

// File: tb/tb_axi4_lite_bus_join_rd.sv
// Directed bench for axi4_lite_bus_join_rd; watchdog steps follow
// AXI4_LITE_BUS_JOIN_RD_WATCHDOG_EN.
module tb_axi4_lite_bus_join_rd;
  import axi4_lite_pkg::*;

  localparam axi4_lite_cfg_t CFG = AXI4_LITE_CFG_DEFAULT;

  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  logic timeout_o;
  int   errors = 0;
  int   checks = 0;

  axi4_lite_if #(.C(CFG)) s_if [2] ();
  axi4_lite_if #(.C(CFG)) m_if ();

  axi4_lite_bus_join_rd #(.C(CFG), .TIMEOUT(16)) dut (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .axi4_s    (s_if),
    .axi4_m    (m_if),
    .timeout_o (timeout_o)
  );

  always #5 aclk = ~aclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #2;
  endtask

  initial begin
    s_if[0].arvalid = 1'b0; s_if[0].araddr = '0; s_if[0].arprot = '0; s_if[0].rready = 1'b0;
    s_if[1].arvalid = 1'b0; s_if[1].araddr = '0; s_if[1].arprot = '0; s_if[1].rready = 1'b0;
    s_if[0].awvalid = 1'b0; s_if[0].awaddr = '0; s_if[0].awprot = '0;
    s_if[0].wvalid = 1'b0; s_if[0].wdata = '0; s_if[0].wstrb = '0; s_if[0].bready = 1'b0;
    s_if[1].awvalid = 1'b0; s_if[1].awaddr = '0; s_if[1].awprot = '0;
    s_if[1].wvalid = 1'b0; s_if[1].wdata = '0; s_if[1].wstrb = '0; s_if[1].bready = 1'b0;
    m_if.arready = 1'b0; m_if.rvalid = 1'b0; m_if.rdata = '0; m_if.rresp = '0;
    m_if.awready = 1'b0; m_if.wready = 1'b0; m_if.bvalid = 1'b0; m_if.bresp = '0;

    // Reset state and write-channel tie-offs
    tick();
    #1;
    check("rst_m_arvalid", 32'(m_if.arvalid), 32'h0);
    check("rst_m_araddr", 32'(m_if.araddr), 32'h0);
    check("rst_m_arprot", 32'(m_if.arprot), 32'h0);
    check("rst_m_rready", 32'(m_if.rready), 32'h0);
    check("rst_s_ready_valid", 32'({s_if[0].arready, s_if[0].rvalid, s_if[1].arready, s_if[1].rvalid}), 32'h0);
    check("rst_timeout", 32'(timeout_o), 32'h0);
    check("tie_s0_wr", 32'({s_if[0].awready, s_if[0].wready, s_if[0].bvalid, s_if[0].bresp}), 32'h0);
    check("tie_s1_wr", 32'({s_if[1].awready, s_if[1].wready, s_if[1].bvalid, s_if[1].bresp}), 32'h0);
    check("tie_m_wr", 32'({m_if.awvalid, m_if.wvalid, m_if.bready, m_if.awprot}), 32'h0);
    check("tie_m_wpay", m_if.awaddr | m_if.wdata | 32'(m_if.wstrb), 32'h0);
    aresetn = 1'b1;

    // Simultaneous requests alternate 0,1,0,1
    s_if[0].arvalid = 1'b1; s_if[0].araddr = 32'h100; s_if[0].rready = 1'b1;
    s_if[1].arvalid = 1'b1; s_if[1].araddr = 32'h200; s_if[1].rready = 1'b1;
    m_if.arready = 1'b1; m_if.rvalid = 1'b1; m_if.rresp = 2'b00;
    for (int k = 0; k < 4; k++) begin
      m_if.rdata = 32'hD0 + 32'(k);
      tick();
      #1;
      check("alt_araddr", m_if.araddr, (k % 2 == 0) ? 32'h100 : 32'h200);
      check("alt_arready", 32'({s_if[1].arready, s_if[0].arready}), (k % 2 == 0) ? 32'h1 : 32'h2);
      tick();
      #1;
      check("alt_arvalid_data", 32'(m_if.arvalid), 32'h0);
      check("alt_rvalid", 32'({s_if[1].rvalid, s_if[0].rvalid}), (k % 2 == 0) ? 32'h1 : 32'h2);
      check("alt_rdata", (k % 2 == 0) ? s_if[0].rdata : s_if[1].rdata, 32'hD0 + 32'(k));
      tick();
      if (k == 3) begin
        s_if[0].arvalid = 1'b0; s_if[1].arvalid = 1'b0; m_if.rvalid = 1'b0;
      end
      #1;
      check("alt_idle_arvalid", 32'(m_if.arvalid), 32'h0);
    end

    // Backpressure: AR stalls 5 cycles, requester R stalls 3 cycles
    s_if[1].arvalid = 1'b1; s_if[1].araddr = 32'h300; s_if[1].arprot = 3'b101;
    s_if[1].rready = 1'b0; m_if.arready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      #1;
      check("bp_araddr_hold", m_if.araddr, 32'h300);
      check("bp_arvalid_hold", 32'({m_if.arvalid, s_if[1].arready, s_if[0].arready}), 32'h4);
    end
    m_if.arready = 1'b1;
    #1;
    check("bp_arready_pass", 32'({s_if[1].arready, m_if.arprot}), 32'hD);
    tick();
    s_if[1].arvalid = 1'b0; m_if.arready = 1'b0;
    m_if.rvalid = 1'b1; m_if.rdata = 32'hCAFE0001;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("bp_rdata_hold", s_if[1].rdata, 32'hCAFE0001);
      check("bp_rvalid_hold", 32'({s_if[1].rvalid, m_if.rready, s_if[0].rvalid}), 32'h4);
      tick();
    end
    s_if[1].rready = 1'b1;
    #1;
    check("bp_rready_pass", 32'(m_if.rready), 32'h1);
    tick();
    m_if.rvalid = 1'b0;
    #1;
    check("bp_done", 32'({s_if[1].rvalid, m_if.arvalid, m_if.rready}), 32'h0);

    // Single request from port 0, slave answers after 2 DATA cycles
    s_if[0].arvalid = 1'b1; s_if[0].araddr = 32'h10; s_if[0].arprot = 3'b010;
    s_if[0].rready = 1'b1; m_if.arready = 1'b1;
    #1;
    check("single_cycle0_arvalid", 32'(m_if.arvalid), 32'h0);
    tick();
    #1;
    check("single_cycle1_arvalid", 32'(m_if.arvalid), 32'h1);
    check("single_araddr", m_if.araddr, 32'h10);
    check("single_arprot", 32'(m_if.arprot), 32'h2);
    check("single_arready", 32'({s_if[1].arready, s_if[0].arready}), 32'h1);
    tick();
    s_if[0].arvalid = 1'b0;
    #1;
    check("single_wait1", 32'({s_if[0].rvalid, m_if.rready}), 32'h1);
    tick();
    #1;
    check("single_wait2", 32'(s_if[0].rvalid), 32'h0);
    tick();
    m_if.rvalid = 1'b1; m_if.rdata = 32'hDEADBEEF; m_if.rresp = 2'b00;
    #1;
    check("single_rvalid", 32'({s_if[0].rvalid, s_if[1].rvalid}), 32'h2);
    check("single_rdata", s_if[0].rdata, 32'hDEADBEEF);
    check("single_rresp", 32'(s_if[0].rresp), 32'h0);
    tick();
    m_if.rvalid = 1'b0;
    #1;
    check("single_idle", 32'({s_if[0].rvalid, m_if.rready}), 32'h0);

`ifdef AXI4_LITE_BUS_JOIN_RD_WATCHDOG_EN
    // Slave never answers: SLVERR after 16 DATA cycles, late response drained
    s_if[0].arvalid = 1'b1; s_if[0].araddr = 32'h20; s_if[0].rready = 1'b0;
    tick();
    tick();
    s_if[0].arvalid = 1'b0;
    for (int k = 0; k < 16; k++) begin
      #1;
      check("wd_wait", 32'({s_if[0].rvalid, timeout_o}), 32'h0);
      tick();
    end
    #1;
    check("wd_err_rvalid", 32'(s_if[0].rvalid), 32'h1);
    check("wd_err_rresp", 32'(s_if[0].rresp), 32'h2);
    check("wd_err_rdata", s_if[0].rdata, 32'h0);
    check("wd_timeout_pulse", 32'(timeout_o), 32'h1);
    check("wd_err_m_rready", 32'(m_if.rready), 32'h0);
    tick();
    #1;
    check("wd_pulse_end", 32'({timeout_o, s_if[0].rvalid}), 32'h1);
    s_if[0].rready = 1'b1;
    tick();
    m_if.rvalid = 1'b1; m_if.rdata = 32'h1234;
    #1;
    check("wd_drain_absorb", 32'({s_if[0].rvalid, m_if.rready}), 32'h1);
    check("wd_drain_rdata", s_if[0].rdata, 32'h0);
    tick();
    m_if.rvalid = 1'b0;
    #1;
    check("wd_drain_exit", 32'(m_if.rready), 32'h0);

    // Handshake on the last counted cycle beats the watchdog
    s_if[0].arvalid = 1'b1; s_if[0].araddr = 32'h30;
    tick();
    tick();
    s_if[0].arvalid = 1'b0;
    for (int k = 0; k < 15; k++) begin
      #1;
      check("wd_edge_wait", 32'(s_if[0].rvalid), 32'h0);
      tick();
    end
    m_if.rvalid = 1'b1; m_if.rdata = 32'hA5A5A5A5; m_if.rresp = 2'b00;
    #1;
    check("wd_edge_rdata", s_if[0].rdata, 32'hA5A5A5A5);
    check("wd_edge_rresp", 32'({s_if[0].rvalid, s_if[0].rresp}), 32'h4);
    tick();
    m_if.rvalid = 1'b0;
    #1;
    check("wd_edge_no_timeout", 32'({timeout_o, s_if[0].rvalid, m_if.arvalid}), 32'h0);
`endif

    // Reset during DATA with port 1 in flight; port 0 must win afterwards
    s_if[1].arvalid = 1'b1; s_if[1].araddr = 32'h600; s_if[1].rready = 1'b1;
    m_if.arready = 1'b1; m_if.rvalid = 1'b0;
    tick();
    tick();
    s_if[1].arvalid = 1'b0; m_if.rvalid = 1'b1; m_if.rdata = 32'h77;
    s_if[1].rready = 1'b0;
    #1;
    check("mid_rvalid_before", 32'(s_if[1].rvalid), 32'h1);
    #1;
    aresetn = 1'b0;
    #1;
    check("mid_async_valids", 32'({s_if[1].rvalid, s_if[0].rvalid, m_if.arvalid, m_if.rready}), 32'h0);
    check("mid_async_araddr", m_if.araddr, 32'h0);
    check("mid_async_timeout", 32'(timeout_o), 32'h0);
    tick();
    aresetn = 1'b1; m_if.rvalid = 1'b0;
    s_if[0].arvalid = 1'b1; s_if[0].araddr = 32'h700;
    s_if[1].arvalid = 1'b1; s_if[1].araddr = 32'h800;
    #1;
    check("post_rst_idle", 32'(m_if.arvalid), 32'h0);
    tick();
    #1;
    check("post_rst_port0_wins", m_if.araddr, 32'h700);
    check("post_rst_arready", 32'({s_if[1].arready, s_if[0].arready}), 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/axi4_lite_bus_join_rd.md
# axi4_lite_bus_join_rd

Two-requester AXI4-Lite read arbiter: merges the read channels (AR/R) of two upstream AXI4-Lite masters onto one downstream slave, one transaction in flight at a time, round-robin fairness. It is the inverse of the bus sunder read path: it shares a single peripheral or the sunder's slave port between two requesters. An optional watchdog converts a hung read into a SLVERR response.

## Interface
- C, none, axi4_lite_pkg::axi4_lite_cfg_t bus configuration (address/data widths), shared by all ports
- TIMEOUT, 256, cycles in DATA before watchdog fires (legal 2..65535; used only with watchdog compiled in)
- aclk  in  1  clock; all logic rising-edge
- aresetn  in  1  reset, asynchronous assert, active-low
- axi4_s[2]  axi4_lite_if  -  upstream requester ports; AR and R channels used, AW/W/B outputs tied 0
- axi4_m  axi4_lite_if  -  downstream port; AR and R channels driven, AW/W/B outputs tied 0
- timeout_o  out  1  one-cycle pulse when the watchdog returns SLVERR; constant 0 without watchdog

## Operation
- States: IDLE, ADDR, DATA; plus ERR, DRAIN with watchdog.
- IDLE: all s.arready, s.rvalid, m.arvalid, m.rready = 0. If any s[i].arvalid, register grant g and go ADDR.
- Arbitration: last_g register, reset 1 (port 0 wins first). One requester: it wins. Both: port != last_g wins. last_g <= g on R handshake (or ERR completion).
- ADDR: m.arvalid = 1; m.araddr/arprot = s[g] values (combinational mux; requester holds them per AXI). s[g].arready = m.arready; other port arready = 0. On m.arvalid & m.arready -> DATA.
- DATA: s[g].rvalid = m.rvalid; s[g].rdata/rresp = m values; m.rready = s[g].rready. On R handshake -> IDLE.
- Non-granted port sees arready = 0, rvalid = 0 throughout; its arvalid is held and served next.
- ERR (watchdog): s[g].rvalid = 1, rresp = 2'b10 (SLVERR), rdata = 0; m.rready = 0. timeout_o pulses on first ERR cycle. On s[g].rready -> DRAIN.
- DRAIN: m.rready = 1, no grants. On m.rvalid (late response discarded) or another TIMEOUT cycles elapsed -> IDLE.
- Reset mid-operation: state -> IDLE, last_g -> 1, counter -> 0 immediately; in-flight transaction abandoned.

## Timing
- Reset values: all interface valids/readies 0, m.araddr 0, m.arprot 0, timeout_o 0.
- s.arvalid at cycle 0 -> m.arvalid at cycle 1 (one-cycle arbitration latency). AR and R paths otherwise combinational pass-through, no added latency.
- Minimum per transaction: 3 cycles (IDLE, ADDR, DATA) with ready slave and requester.
- Back-to-back: IDLE re-entered after R handshake; next grant decided that cycle.
- Watchdog counter: cleared on entering DATA, +1 per DATA cycle without R handshake; on count == TIMEOUT-1 and no handshake -> ERR. Handshake on the same cycle wins over timeout. Counter width $clog2(TIMEOUT+1), saturates, no wrap.
- ADDR has no timeout (AR stall is a slave protocol hold, not a hang).

## Configuration
- AXI4_LITE_BUS_JOIN_RD_WATCHDOG_EN defined: counter, ERR and DRAIN states, timeout_o pulses as above.
- Undefined: no counter; DATA waits indefinitely; ERR/DRAIN unreachable and not synthesized; timeout_o tied 0; TIMEOUT ignored.

## Structure
- axi4_lite_pkg: state enum typedef (IDLE, ADDR, DATA, ERR, DRAIN) and constant for RESP_SLVERR = 2'b10, reusable by the write-side joiner.
- One sub-module: axi4_lite_rr_arb_2 (request[1:0], last_g in -> grant index); pure combinational, shared with a future axi4_lite_bus_join_wr.

## Test plan
- Single request: s[0] reads 0x10, slave returns 0xDEADBEEF OKAY after 2 cycles -> s[0] gets 0xDEADBEEF, rresp 0; m.arvalid first seen cycle 1.
- Simultaneous s[0]/s[1] arvalid, repeated 4 times -> grants alternate 0,1,0,1; never two AR in flight.
- Backpressure: m.arready low 5 cycles, then s[1].rready low 3 cycles -> addresses and data held stable, single handshake each side.
- Watchdog (macro on, TIMEOUT=16): slave never responds -> s[g] gets rresp 2'b10, rdata 0 after 16 DATA cycles, timeout_o one pulse; late slave rvalid absorbed in DRAIN, not forwarded.
- Handshake on timeout cycle: slave rvalid at count 15 -> OKAY data forwarded, no timeout_o.
- aresetn low during DATA -> all outputs 0 asynchronously; after release, port 0 wins first simultaneous request.
